// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the packet arbiter.
// Feature macro STREAM_ARB_FIXED_PRIO_EN is consumed by rr_picker and the top, not here.
package stream_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Width of an index into n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational winner selection for the packet arbiter.
// STREAM_ARB_FIXED_PRIO_EN: lowest set request index wins, no last_grant input.
module rr_picker
    import stream_arb_pkg::*;
#(
    parameter int N_SOURCES = 4,
    parameter int N_WIDTH   = idx_width(N_SOURCES)
) (
    input  logic [N_SOURCES-1:0] req,
`ifndef STREAM_ARB_FIXED_PRIO_EN
    input  logic [N_WIDTH-1:0]   last_grant,
`endif
    output logic [N_WIDTH-1:0]   winner,
    output logic                 any_req
);

    always_comb begin
        logic found;
        winner  = '0;
        any_req = |req;
        found   = 1'b0;
`ifdef STREAM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N_SOURCES; i++) begin
            if (!found && req[i]) begin
                winner = N_WIDTH'(i);
                found  = 1'b1;
            end
        end
`else
        // Scan starts just after the previous owner so it gets lowest priority.
        for (int k = 1; k <= N_SOURCES; k++) begin
            int idx;
            idx = (int'(last_grant) + k) % N_SOURCES;
            if (!found && req[idx]) begin
                winner = N_WIDTH'(idx);
                found  = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/stream_packet_arbiter.sv
// Packet-level arbiter feeding one narrow stream into a shared upsizer, with a registered output slice.
// STREAM_ARB_FIXED_PRIO_EN selects fixed (lowest index) priority instead of round-robin.
module stream_packet_arbiter
    import stream_arb_pkg::*;
#(
    parameter int T_DATA_WIDTH = 1,
    parameter int N_SOURCES    = 4,
    parameter int N_WIDTH      = idx_width(N_SOURCES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [T_DATA_WIDTH-1:0] s_data_i [N_SOURCES],
    input  logic [N_SOURCES-1:0]    s_last_i,
    input  logic [N_SOURCES-1:0]    s_valid_i,
    output logic [N_SOURCES-1:0]    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic [N_WIDTH-1:0]      m_id_o
);

    arb_state_t          state, state_nxt;
    logic [N_WIDTH-1:0]  grant;
    logic [N_WIDTH-1:0]  winner;
    logic                any_req;
    logic                out_free;
    logic                accept;

`ifdef STREAM_ARB_FIXED_PRIO_EN
    rr_picker #(.N_SOURCES(N_SOURCES), .N_WIDTH(N_WIDTH)) u_picker (
        .req     (s_valid_i),
        .winner  (winner),
        .any_req (any_req)
    );
`else
    logic [N_WIDTH-1:0]  last_grant;

    rr_picker #(.N_SOURCES(N_SOURCES), .N_WIDTH(N_WIDTH)) u_picker (
        .req        (s_valid_i),
        .last_grant (last_grant),
        .winner     (winner),
        .any_req    (any_req)
    );
`endif

    // Slice can take a beat when empty or draining this cycle.
    always_comb begin
        out_free  = ~m_valid_o | m_ready_i;
        accept    = (state == ARB_LOCKED) & s_valid_i[grant] & out_free;
        s_ready_o = '0;
        if (state == ARB_LOCKED) s_ready_o[grant] = out_free;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:   if (any_req) state_nxt = ARB_LOCKED;
            ARB_LOCKED: if (accept && s_last_i[grant]) state_nxt = ARB_IDLE;
            default:    state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            grant      <= '0;
`ifndef STREAM_ARB_FIXED_PRIO_EN
            last_grant <= N_WIDTH'(N_SOURCES - 1);
`endif
            m_valid_o  <= 1'b0;
            m_last_o   <= 1'b0;
            m_data_o   <= '0;
            m_id_o     <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARB_IDLE && any_req) grant <= winner;
`ifndef STREAM_ARB_FIXED_PRIO_EN
            if (accept && s_last_i[grant]) last_grant <= grant;
`endif
            if (accept) begin
                m_data_o  <= s_data_i[grant];
                m_last_o  <= s_last_i[grant];
                m_id_o    <= grant;
                m_valid_o <= 1'b1;
            end else if (m_ready_i) begin
                m_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Randomized scoreboard bench for stream_packet_arbiter (N_SOURCES=4, T_DATA_WIDTH=8).
// A packet-rule reference model predicts ready and the forwarded beat order.
module tb_stream_packet_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int NW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  s_data [N];
    logic [N-1:0]  s_last, s_valid, s_ready;
    logic [W-1:0]  m_data;
    logic          m_last, m_valid, m_ready;
    logic [NW-1:0] m_id;

    stream_packet_arbiter #(.T_DATA_WIDTH(W), .N_SOURCES(N), .N_WIDTH(NW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data_i  (s_data),
        .s_last_i  (s_last),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .m_data_o  (m_data),
        .m_last_o  (m_last),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .m_id_o    (m_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  d;
        logic          l;
        logic [NW-1:0] id;
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    // Reference model: packet ownership, rotation pointer, slice occupancy.
    bit mdl_locked;
    int mdl_grant;
    int mdl_ptr;
    bit mdl_full;
    // Per-source packet generator.
    int seq [N];
    int pos [N];
    int len [N];

    function automatic int pick(input logic [N-1:0] v, input int ptr);
`ifdef STREAM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        mdl_locked = 0;
        mdl_grant  = 0;
        mdl_ptr    = N - 1;
        mdl_full   = 0;
        for (int s = 0; s < N; s++) begin
            pos[s] = 0;
            len[s] = $urandom_range(1, 4);
        end
    endtask

    task automatic drive(input int pv, input int pr, input logic [N-1:0] mask);
        for (int s = 0; s < N; s++) begin
            s_valid[s] = mask[s] && ($urandom_range(99) < pv);
            s_data[s]  = {2'(s), 6'(seq[s])};
            s_last[s]  = (pos[s] == len[s] - 1);
        end
        m_ready = ($urandom_range(99) < pr);
    endtask

    // One clock: drive after the edge, check ready mid-cycle, advance the model.
    task automatic cycle(input int pv, input int pr, input logic [N-1:0] mask);
        logic [N-1:0] exp_rdy;
        bit           room;
        @(posedge clk);
        #1;
        drive(pv, pr, mask);
        @(negedge clk);
        exp_rdy = '0;
        room    = !mdl_full || m_ready;
        if (mdl_locked && room) exp_rdy[mdl_grant] = 1'b1;
        checks++;
        if (s_ready !== exp_rdy) begin
            errors++;
            $display("FAIL s_ready t=%0t got=%b want=%b", $time, s_ready, exp_rdy);
        end
        if (!mdl_locked) begin
            if (|s_valid) begin
                mdl_grant  = pick(s_valid, mdl_ptr);
                mdl_locked = 1;
            end
            if (m_ready) mdl_full = 0;
        end else if (s_valid[mdl_grant] && room) begin
            exp_q.push_back('{d: s_data[mdl_grant], l: s_last[mdl_grant], id: NW'(mdl_grant)});
            mdl_full = 1;
            seq[mdl_grant]++;
            if (s_last[mdl_grant]) begin
                mdl_ptr    = mdl_grant;
                mdl_locked = 0;
                pos[mdl_grant] = 0;
                len[mdl_grant] = $urandom_range(1, 4);
            end else begin
                pos[mdl_grant]++;
            end
        end else if (m_ready) begin
            mdl_full = 0;
        end
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== '0 || m_id !== '0 || s_ready !== '0) begin
            errors++;
            $display("FAIL %s got v=%b l=%b d=%h id=%0d rdy=%b want all zero", tag, m_valid, m_last, m_data, m_id, s_ready);
        end
    endtask

    // Reset for one cycle with inputs left active, then one quiet cycle.
    task automatic apply_reset(input string tag);
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        m_ready = 1'b0;
        drive(100, 0, '1);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        s_valid = '0;
        m_ready = 1'b0;
        exp_q.delete();
        model_reset();
        check_reset_state(tag);
    endtask

    // Monitor: pop on every output handshake, and watch stability under backpressure.
    beat_t prev_beat;
    logic  prev_hold = 1'b0;
    always @(negedge clk) begin
        beat_t got;
        got = '{d: m_data, l: m_last, id: m_id};
        if (rst_n && prev_hold) begin
            checks++;
            if (!m_valid || got !== prev_beat) begin
                errors++;
                $display("FAIL stable got v=%b %h want v=1 %h", m_valid, got, prev_beat);
            end
        end
        if (rst_n && m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat unexpected got=%h want=none", got);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL beat got d=%h l=%b id=%0d want d=%h l=%b id=%0d", got.d, got.l, got.id, e.d, e.l, e.id);
                end
            end
        end
        prev_hold = rst_n && m_valid && !m_ready;
        prev_beat = got;
    end

    initial begin
        rst_n   = 1'b0;
        s_valid = '0;
        s_last  = '0;
        m_ready = 1'b0;
        for (int s = 0; s < N; s++) begin
            s_data[s] = '0;
            seq[s]    = 0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_state("reset");

        for (int i = 0; i < 300; i++) cycle(70, 80, 4'b1111);   // mixed traffic
        for (int i = 0; i < 150; i++) cycle(100, 100, 4'b1011); // fairness among 0,1,3
        for (int i = 0; i < 150; i++) cycle(100, 30, 4'b1111);  // heavy backpressure
        for (int i = 0; i < 80;  i++) cycle(100, 100, 4'b0100); // single requester
        for (int i = 0; i < 100; i++) cycle(100, 100, 4'b0110); // two requesters
        for (int i = 0; i < 7;   i++) cycle(100, 100, 4'b1111);
        apply_reset("reset_mid");
        for (int i = 0; i < 200; i++) cycle(60, 60, 4'b1111);
        for (int i = 0; i < 40;  i++) cycle(0, 100, 4'b0000);   // drain

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
